// File: rtl/spi_slave_word.sv
// SPI mode-0 target: oversampled sck/cs/mosi, MSB-first word deserializer with valid/ready
// output, and a single-entry TX holding buffer feeding the MISO shift register.
module spi_slave_word #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  sck_i,
   input  logic                  cs_n_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic                  frame_err_o,
   output logic                  rx_overrun_o,
   output logic                  tx_underrun_o
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sck_prev_q;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise_d, sck_fall_d, word_done_d, load_d;
   logic [DATA_WIDTH-1:0]  rx_word_d;

   state_e                 state_q;
   logic [SW-1:0]          settle_q;
   logic [CW-1:0]          bit_cnt_q;
   logic                   reload_q;
   logic [DATA_WIDTH-1:0]  rx_sh_q, tx_sh_q, tx_buf_q, rx_data_q;
   logic                   tx_full_q, rx_valid_q;
   logic                   frame_err_q, rx_overrun_q, tx_underrun_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sck_prev_q  <= sck_s;
      end
   end

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // A CS rise outranks any sck edge seen in the same cycle.
   assign sck_rise_d  = (state_q == ACTIVE) && !cs_s && !sck_prev_q && sck_s;
   assign sck_fall_d  = (state_q == ACTIVE) && !cs_s && sck_prev_q && !sck_s;
   assign word_done_d = sck_rise_d && (bit_cnt_q == CW'(DATA_WIDTH - 1));
   assign rx_word_d   = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
   assign load_d      = ((state_q == IDLE) && !cs_s) || (sck_fall_d && reload_q);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_CS_HIGH;
         settle_q      <= '0;
         bit_cnt_q     <= '0;
         reload_q      <= 1'b0;
         rx_sh_q       <= '0;
         tx_sh_q       <= '0;
         tx_buf_q      <= '0;
         tx_full_q     <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         frame_err_q   <= 1'b0;
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;

         // Accept only fills an empty buffer; a load only empties a full one.
         if (tx_valid_i && !tx_full_q) begin
            tx_buf_q  <= tx_data_i;
            tx_full_q <= 1'b1;
         end
         if (load_d) begin
            if (tx_full_q) begin
               tx_sh_q   <= tx_buf_q;
               tx_full_q <= 1'b0;
            end else begin
               tx_sh_q       <= '0;
               tx_underrun_q <= 1'b1;
            end
         end

         if (rx_valid_q && rx_ready_i)
            rx_valid_q <= 1'b0;
         if (word_done_d) begin
            if (rx_valid_q && !rx_ready_i) begin
               rx_overrun_q <= 1'b1;
            end else begin
               rx_data_q  <= rx_word_d;
               rx_valid_q <= 1'b1;
            end
         end

         case (state_q)
            // Synchronizers start out reading CS high; let them fill before trusting cs_s.
            WAIT_CS_HIGH: begin
               if (settle_q != SW'(SYNC_STAGES))
                  settle_q <= settle_q + 1'b1;
               else if (cs_s)
                  state_q <= IDLE;
            end
            IDLE: begin
               if (!cs_s)
                  state_q <= ACTIVE;
            end
            ACTIVE: begin
               if (cs_s) begin
                  state_q   <= IDLE;
                  bit_cnt_q <= '0;
                  reload_q  <= 1'b0;
                  rx_sh_q   <= '0;
                  if (bit_cnt_q != '0)
                     frame_err_q <= 1'b1;
               end else if (sck_rise_d) begin
                  rx_sh_q <= rx_word_d;
                  if (word_done_d) begin
                     bit_cnt_q <= '0;
                     reload_q  <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else if (sck_fall_d) begin
                  if (reload_q)
                     reload_q <= 1'b0;
                  else if (bit_cnt_q != '0)
                     tx_sh_q <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
            default: state_q <= WAIT_CS_HIGH;
         endcase
      end
   end

   assign miso_oe_o     = (state_q == ACTIVE);
   assign miso_o        = (state_q == ACTIVE) && tx_sh_q[DATA_WIDTH-1];
   assign tx_ready_o    = !tx_full_q;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign frame_err_o   = frame_err_q;
   assign rx_overrun_o  = rx_overrun_q;
   assign tx_underrun_o = tx_underrun_q;
endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: acts as the mode-0 initiator at sck = clk/8 and checks
// against a word-level model of the TX buffer and RX handshake.
module tb_spi_slave_word;
   localparam int W = 32;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic          miso_o, miso_oe_o, tx_ready_o, rx_valid_o;
   logic          frame_err_o, rx_overrun_o, tx_underrun_o;
   logic [W-1:0]  tx_data = '0, rx_data_o;
   logic          tx_valid = 1'b0, rx_ready = 1'b0;

   int checks = 0, errors = 0;
   int n_ferr = 0, n_ovr = 0, n_und = 0;
   int e_ferr = 0, e_ovr = 0, e_und = 0;

   bit            m_full = 0;
   logic [W-1:0]  m_buf = '0;
   bit            m_rxv = 0;
   logic [W-1:0]  m_rxd = '0;

   spi_slave_word #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_n(rst_n), .sck_i(sck), .cs_n_i(cs_n), .mosi_i(mosi),
      .miso_o(miso_o), .miso_oe_o(miso_oe_o),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
      .frame_err_o(frame_err_o), .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err_o)   n_ferr++;
      if (rx_overrun_o)  n_ovr++;
      if (tx_underrun_o) n_und++;
   end

   // Model of one shift-register load from the single-entry buffer.
   task automatic m_load(output logic [W-1:0] v);
      if (m_full) begin
         v = m_buf;
         m_full = 0;
      end else begin
         v = '0;
         e_und++;
      end
   endtask

   task automatic push(input logic [W-1:0] d);
      @(negedge clk);
      checks++;
      if (tx_ready_o !== 1'b1) begin
         errors++; $display("FAIL push_ready_before got %b exp 1", tx_ready_o);
      end
      tx_data = d; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      m_full = 1; m_buf = d;
      checks++;
      if (tx_ready_o !== 1'b0) begin
         errors++; $display("FAIL push_ready_after got %b exp 0", tx_ready_o);
      end
   endtask

   task automatic consume();
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      m_rxv = 0;
      checks++;
      if (rx_valid_o !== 1'b0) begin
         errors++; $display("FAIL consume_clears got %b exp 0", rx_valid_o);
      end
   endtask

   // One sck period; rdy_pulse raises rx_ready only in the cycle the DUT acts on this rise.
   task automatic bit_xfer(input logic b, input bit rdy_pulse, output logic s);
      mosi = b;
      repeat (4) @(negedge clk);
      s = miso_o;
      sck = 1'b1;
      if (rdy_pulse) begin
         @(posedge clk); @(posedge clk); @(negedge clk);
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      sck = 1'b0;
   endtask

   task automatic xfer_word(input logic [W-1:0] mw, input int nbits, input bit rdy,
                            output logic [W-1:0] sw);
      logic s;
      sw = '0;
      for (int i = W - 1; i >= W - nbits; i--) begin
         bit_xfer(mw[i], rdy && (i == 0), s);
         sw[i] = s;
      end
   endtask

   task automatic frame(input int nw, input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input bit do_refill, input logic [W-1:0] refill,
                        input bit rdy_last, input bit cons_each);
      logic [W-1:0] exp_m, got_m, word;
      bit rdy;
      @(negedge clk);
      cs_n = 1'b0;
      m_load(exp_m);
      repeat (6) @(negedge clk);
      checks++;
      if (miso_oe_o !== 1'b1) begin
         errors++; $display("FAIL frame_oe got %b exp 1", miso_oe_o);
      end
      checks++;
      if (n_und !== e_und) begin
         errors++; $display("FAIL frame_start_underrun got %0d exp %0d", n_und, e_und);
      end
      if (do_refill) push(refill);
      for (int k = 0; k < nw; k++) begin
         word = (k == 0) ? w0 : w1;
         rdy  = rdy_last && (k == nw - 1);
         xfer_word(word, W, rdy, got_m);
         checks++;
         if (got_m !== exp_m) begin
            errors++; $display("FAIL miso_word%0d got %h exp %h", k, got_m, exp_m);
         end
         if (m_rxv && !rdy) begin
            e_ovr++;
         end else begin
            m_rxd = word; m_rxv = 1;
         end
         m_load(exp_m);
         checks++;
         if (rx_valid_o !== m_rxv || rx_data_o !== m_rxd) begin
            errors++;
            $display("FAIL rx_word%0d got v=%b d=%h exp v=%b d=%h", k, rx_valid_o, rx_data_o, m_rxv, m_rxd);
         end
         if (cons_each && k < nw - 1) consume();
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (miso_oe_o !== 1'b0 || miso_o !== 1'b0) begin
         errors++; $display("FAIL frame_end_idle got oe=%b miso=%b exp 0 0", miso_oe_o, miso_o);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || tx_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_tx got miso=%b oe=%b rdy=%b exp 0 0 1", miso_o, miso_oe_o, tx_ready_o);
      end
      checks++;
      if (rx_valid_o !== 1'b0 || rx_data_o !== '0) begin
         errors++; $display("FAIL reset_rx got v=%b d=%h exp 0 0", rx_valid_o, rx_data_o);
      end
      checks++;
      if ({frame_err_o, rx_overrun_o, tx_underrun_o} !== 3'b000) begin
         errors++; $display("FAIL reset_pulses got %b exp 000", {frame_err_o, rx_overrun_o, tx_underrun_o});
      end
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_single();
      push(32'hA5A50F0F);
      frame(1, 32'h12345678, '0, 1, $urandom, 0, 0);
      repeat (5) @(negedge clk);
      checks++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h12345678) begin
         errors++; $display("FAIL single_hold got v=%b d=%h exp 1 12345678", rx_valid_o, rx_data_o);
      end
      checks++;
      if (n_ferr !== 0 || n_ovr !== 0 || n_und !== 0) begin
         errors++; $display("FAIL single_pulses got %0d %0d %0d exp 0 0 0", n_ferr, n_ovr, n_und);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      push($urandom);
      frame(2, 32'hDEADBEEF, 32'h00000001, 1, 32'hCAFEF00D, 0, 1);
      checks++;
      if (n_und !== e_und || n_ovr !== e_ovr) begin
         errors++; $display("FAIL b2b_pulses got und=%0d ovr=%0d exp %0d %0d", n_und, n_ovr, e_und, e_ovr);
      end
      consume();
   endtask

   task automatic test_underrun();
      checks++;
      if (tx_ready_o !== 1'b1) begin
         errors++; $display("FAIL underrun_buf_empty got %b exp 1", tx_ready_o);
      end
      frame(1, $urandom, '0, 0, '0, 0, 0);
      checks++;
      if (n_und !== e_und) begin
         errors++; $display("FAIL underrun_count got %0d exp %0d", n_und, e_und);
      end
      consume();
   endtask

   task automatic test_overrun();
      logic [W-1:0] a, b;
      a = $urandom; b = $urandom;
      frame(2, a, b, 0, '0, 0, 0);
      checks++;
      if (n_ovr !== e_ovr || rx_data_o !== a) begin
         errors++; $display("FAIL overrun_keep got ovr=%0d d=%h exp %0d %h", n_ovr, rx_data_o, e_ovr, a);
      end
      consume();
      a = $urandom; b = $urandom;
      frame(2, a, b, 0, '0, 1, 0);
      checks++;
      if (n_ovr !== e_ovr || rx_data_o !== b || rx_valid_o !== 1'b1) begin
         errors++; $display("FAIL overrun_ready got ovr=%0d d=%h v=%b exp %0d %h 1", n_ovr, rx_data_o, rx_valid_o, e_ovr, b);
      end
      consume();
   endtask

   task automatic test_abort();
      logic [W-1:0] exp_m, got_m;
      @(negedge clk);
      cs_n = 1'b0;
      m_load(exp_m);
      repeat (6) @(negedge clk);
      xfer_word($urandom, 13, 0, got_m);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      e_ferr++;
      repeat (6) @(negedge clk);
      checks++;
      if (got_m[W-1:W-13] !== exp_m[W-1:W-13]) begin
         errors++; $display("FAIL abort_miso got %h exp %h", got_m[W-1:W-13], exp_m[W-1:W-13]);
      end
      checks++;
      if (n_ferr !== e_ferr || rx_valid_o !== 1'b0) begin
         errors++; $display("FAIL abort_err got ferr=%0d v=%b exp %0d 0", n_ferr, rx_valid_o, e_ferr);
      end
      push($urandom);
      frame(1, $urandom, '0, 0, '0, 0, 0);
      checks++;
      if (n_ferr !== e_ferr || n_und !== e_und) begin
         errors++; $display("FAIL abort_next got ferr=%0d und=%0d exp %0d %0d", n_ferr, n_und, e_ferr, e_und);
      end
      consume();
   endtask

   task automatic test_reset_mid_frame();
      logic [W-1:0] exp_m, got_m;
      push($urandom);
      @(negedge clk);
      cs_n = 1'b0;
      m_load(exp_m);
      repeat (6) @(negedge clk);
      xfer_word($urandom, 10, 0, got_m);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      m_full = 0; m_rxv = 0; m_rxd = '0;
      @(negedge clk);
      checks++;
      if (miso_o !== 1'b0 || miso_oe_o !== 1'b0 || tx_ready_o !== 1'b1 ||
          rx_valid_o !== 1'b0 || rx_data_o !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got miso=%b oe=%b rdy=%b v=%b d=%h exp 0 0 1 0 0",
                  miso_o, miso_oe_o, tx_ready_o, rx_valid_o, rx_data_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer_word($urandom, W, 0, got_m);
      repeat (4) @(negedge clk);
      checks++;
      if (rx_valid_o !== 1'b0 || miso_oe_o !== 1'b0 || n_und !== e_und || n_ferr !== e_ferr) begin
         errors++;
         $display("FAIL midreset_ignored got v=%b oe=%b und=%0d ferr=%0d exp 0 0 %0d %0d",
                  rx_valid_o, miso_oe_o, n_und, n_ferr, e_und, e_ferr);
      end
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      frame(1, $urandom, '0, 0, '0, 0, 0);
      checks++;
      if (n_und !== e_und || n_ovr !== e_ovr || n_ferr !== e_ferr) begin
         errors++; $display("FAIL midreset_next got %0d %0d %0d exp %0d %0d %0d", n_und, n_ovr, n_ferr, e_und, e_ovr, e_ferr);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
